// File: rtl/song_sequencer_pkg.sv
// Shared constants for the song sequencer: record layout and FSM states.
// Optional build macro: SONG_SEQ_LOOP_EN (see song_sequencer.sv).
package song_sequencer_pkg;

    localparam int OCTAVE_BITS = 3;
    localparam int NOTE_BITS   = 3;
    localparam int LENGTH_BITS = 3;
    localparam int REC_W       = 10;

    localparam int END_BIT = 9;
    localparam int OCT_HI  = 8;
    localparam int OCT_LO  = 6;
    localparam int NOTE_HI = 5;
    localparam int NOTE_LO = 3;
    localparam int LEN_HI  = 2;
    localparam int LEN_LO  = 0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_PLAY,
        S_ARM,
        S_WAIT,
        S_GAP,
        S_PAUSED,
        S_END
    } seq_state_e;

endpackage

// File: rtl/song_sequencer_if.sv
// Song ROM read port plus note-engine command/status bundle.
// master = sequencer side, slave = ROM/engine side.
interface song_sequencer_if
    import song_sequencer_pkg::*;
#(
    parameter int ADDR_W = 8
) ();

    logic [ADDR_W-1:0]      rom_addr;
    logic [REC_W-1:0]       rom_data;
    logic                   snd_start;
    logic [OCTAVE_BITS-1:0] snd_octave;
    logic [NOTE_BITS-1:0]   snd_note;
    logic [LENGTH_BITS-1:0] snd_length;
    logic                   snd_over;

    modport master (
        output rom_addr,
        output snd_start,
        output snd_octave,
        output snd_note,
        output snd_length,
        input  rom_data,
        input  snd_over
    );

    modport slave (
        input  rom_addr,
        input  snd_start,
        input  snd_octave,
        input  snd_note,
        input  snd_length,
        output rom_data,
        output snd_over
    );

endinterface

// File: rtl/song_sequencer_gap_timer.sv
// Loadable down-counter with zero flag; holds at zero.
module gap_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] value_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (dec_i && cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/song_sequencer.sv
// Autoplay sequencer: walks a song in ROM, one note at a time to the engine.
// Define SONG_SEQ_LOOP_EN to add the 'loop' input (repeat at end marker).
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int SONG_W     = 2,
    parameter int GAP_CYCLES = 5000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     pause_tgl,
    input  logic [SONG_W-1:0]        song_sel,
`ifdef SONG_SEQ_LOOP_EN
    input  logic                     loop,
`endif
    song_sequencer_if.master         bus,
    output logic                     busy,
    output logic                     paused,
    output logic                     done,
    output logic [ADDR_W-SONG_W-1:0] position
);

    localparam int OFS_W = ADDR_W - SONG_W;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    seq_state_e state_q, state_d;

    logic [SONG_W-1:0]      song_q, song_d;
    logic [OFS_W-1:0]       ofs_q, ofs_d;
    logic                   pause_q, pause_d;
    logic [OCTAVE_BITS-1:0] oct_q, oct_d;
    logic [NOTE_BITS-1:0]   note_q, note_d;
    logic [LENGTH_BITS-1:0] len_q, len_d;

    logic gap_load, gap_dec, gap_zero;
    logic rec_end, ofs_last, loop_hit;

    assign rec_end  = bus.rom_data[END_BIT];
    assign ofs_last = &ofs_q;

`ifdef SONG_SEQ_LOOP_EN
    // An end marker at offset 0 is an empty song; never loop on it.
    assign loop_hit = loop && (ofs_q != '0);
`else
    assign loop_hit = 1'b0;
`endif

    gap_timer #(
        .W(GAP_W)
    ) u_gap (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (gap_load),
        .dec_i   (gap_dec),
        .value_i (GAP_LOAD),
        .zero_o  (gap_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            song_q  <= '0;
            ofs_q   <= '0;
            pause_q <= 1'b0;
            oct_q   <= '0;
            note_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            song_q  <= song_d;
            ofs_q   <= ofs_d;
            pause_q <= pause_d;
            oct_q   <= oct_d;
            note_q  <= note_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        song_d   = song_q;
        ofs_d    = ofs_q;
        pause_d  = pause_q;
        oct_d    = oct_q;
        note_d   = note_q;
        len_d    = len_q;
        gap_load = 1'b0;
        gap_dec  = 1'b0;

        if (pause_tgl && state_q != S_IDLE
                && state_q != S_PAUSED) begin
            pause_d = !pause_q;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    song_d  = song_sel;
                    ofs_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                if (rec_end) begin
                    if (loop_hit) begin
                        ofs_d   = '0;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_END;
                    end
                end else begin
                    if (!stop) begin
                        oct_d  = bus.rom_data[OCT_HI:OCT_LO];
                        note_d = bus.rom_data[NOTE_HI:NOTE_LO];
                        len_d  = bus.rom_data[LEN_HI:LEN_LO];
                    end
                    state_d = S_PLAY;
                end
            end
            S_PLAY: state_d = S_ARM;
            S_ARM:  state_d = S_WAIT;
            S_WAIT: begin
                if (bus.snd_over) begin
                    gap_load = 1'b1;
                    state_d  = S_GAP;
                end
            end
            S_GAP: begin
                gap_dec = 1'b1;
                if (gap_zero) begin
                    // Last offset of the song slot: finish rather than wrap.
                    if (ofs_last) begin
                        state_d = S_END;
                    end else begin
                        ofs_d   = ofs_q + OFS_W'(1);
                        state_d = pause_q ? S_PAUSED : S_FETCH;
                    end
                end
            end
            S_PAUSED: begin
                if (pause_tgl) begin
                    pause_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_END: begin
                pause_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (stop) begin
            state_d = S_IDLE;
            pause_d = 1'b0;
        end
    end

    always_comb begin
        busy          = (state_q != S_IDLE);
        paused        = (state_q == S_PAUSED);
        done          = (state_q == S_END) && !stop;
        bus.snd_start = (state_q == S_PLAY) && !stop;
        position      = busy ? ofs_q : '0;
    end

    assign bus.rom_addr   = {song_q, ofs_q};
    assign bus.snd_octave = oct_q;
    assign bus.snd_note   = note_q;
    assign bus.snd_length = len_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a ROM and note-engine model.
module tb_song_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause_tgl = 1'b0;
    logic [1:0] song_sel = 2'd0;
    logic       busy, paused, done;
    logic [5:0] position;
`ifdef SONG_SEQ_LOOP_EN
    logic       loop = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    song_sequencer_if #(.ADDR_W(8)) bus ();

    song_sequencer #(
        .ADDR_W(8),
        .SONG_W(2),
        .GAP_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .pause_tgl (pause_tgl),
        .song_sel  (song_sel),
`ifdef SONG_SEQ_LOOP_EN
        .loop      (loop),
`endif
        .bus       (bus),
        .busy      (busy),
        .paused    (paused),
        .done      (done),
        .position  (position)
    );

    always #5 clk = ~clk;

    logic [9:0] rom [0:255];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    int eng_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.snd_over <= 1'b1;
            eng_cnt <= 0;
        end else if (bus.snd_start) begin
            bus.snd_over <= 1'b0;
            eng_cnt <= int'(bus.snd_length) + 2;
        end else if (eng_cnt > 1) begin
            eng_cnt <= eng_cnt - 1;
        end else begin
            bus.snd_over <= 1'b1;
        end
    end

    int n_start = 0;
    int n_done = 0;
    logic [8:0] log_rec [0:255];
    always @(negedge clk) begin
        if (bus.snd_start) begin
            log_rec[n_start[7:0]] <= {bus.snd_octave,
                bus.snd_note, bus.snd_length};
            n_start <= n_start + 1;
        end
        if (done) n_done <= n_done + 1;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [1:0] sel);
        @(negedge clk);
        start = 1'b1;
        song_sel = sel;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_pause();
        pause_tgl = 1'b1;
        @(negedge clk);
        pause_tgl = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        for (int k = 0; k < max; k++) begin
            @(negedge clk);
            if (done) break;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_addr"}, 32'(bus.rom_addr), 32'd0);
        check({tag, "_snd"}, {22'd0, bus.snd_start,
            bus.snd_octave, bus.snd_note, bus.snd_length}, 32'd0);
        check({tag, "_flags"}, {29'd0, busy, paused, done}, 32'd0);
        check({tag, "_pos"}, 32'(position), 32'd0);
    endtask

    int bs, bd;

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 10'h200;
        rom[8'h40] = 10'b0_100_001_010;
        rom[8'h41] = 10'b0_100_011_001;
        rom[8'h80] = 10'b0_010_101_001;
        rom[8'h81] = 10'b0_011_000_001;
        for (int i = 0; i < 64; i++) begin
            rom[8'hC0 + i] = {1'b0, 3'(i), 3'd1, 3'd0};
        end

        idle(3);
        check_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // Basic two-note song
        bs = n_start; bd = n_done;
        do_start(2'd1);
        check("fetch_addr", 32'(bus.rom_addr), 32'h40);
        check("fetch_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("latch_nostart", 32'(bus.snd_start), 32'd0);
        @(negedge clk);
        check("play_start", 32'(bus.snd_start), 32'd1);
        check("play_fields", {bus.snd_octave, bus.snd_note,
            bus.snd_length}, 32'(9'b100_001_010));
        wait_done("song1_done", 200);
        check("song1_busy_at_done", 32'(busy), 32'd1);
        @(negedge clk);
        check("song1_idle", 32'(busy), 32'd0);
        check("song1_starts", n_start - bs, 32'd2);
        check("song1_dones", n_done - bd, 32'd1);
        check("song1_note2", 32'(log_rec[bs[7:0] + 1]),
            32'(9'b100_011_001));

        // Pause during first WAIT
        bs = n_start; bd = n_done;
        do_start(2'd1);
        idle(4);
        pulse_pause();
        for (int k = 0; k < 100; k++) begin
            if (paused) break;
            @(negedge clk);
        end
        check("pause_paused", 32'(paused), 32'd1);
        check("pause_pos", 32'(position), 32'd1);
        idle(20);
        check("pause_hold", 32'(paused), 32'd1);
        check("pause_starts", n_start - bs, 32'd1);
        pulse_pause();
        check("pause_resumed", 32'(paused), 32'd0);
        wait_done("pause_done", 200);
        idle(2);
        check("pause_starts2", n_start - bs, 32'd2);
        check("pause_dones", n_done - bd, 32'd1);

        // Stop during WAIT, then replay
        bs = n_start; bd = n_done;
        do_start(2'd1);
        idle(4);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_idle", 32'(busy), 32'd0);
        check("stop_pos", 32'(position), 32'd0);
        check("stop_hold", 32'(bus.snd_length), 32'd2);
        idle(30);
        check("stop_starts", n_start - bs, 32'd1);
        check("stop_dones", n_done - bd, 32'd0);
        do_start(2'd1);
        check("replay_pos", 32'(position), 32'd0);
        check("replay_addr", 32'(bus.rom_addr), 32'h40);

        // Start while busy is ignored, then stop+start together
        do_start(2'd0);
        check("busy_start_song", 32'(bus.rom_addr[7:6]), 32'd1);
        check("busy_start_busy", 32'(busy), 32'd1);
        stop = 1'b1;
        start = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        start = 1'b0;
        check("stop_start_busy", 32'(busy), 32'd0);
        stop = 1'b1;
        start = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        start = 1'b0;
        check("stop_start_idle", 32'(busy), 32'd0);

        // Empty song: done at start+3, no notes
        bs = n_start;
        do_start(2'd0);
        @(negedge clk);
        check("empty_early", 32'(done), 32'd0);
        @(negedge clk);
        check("empty_done", 32'(done), 32'd1);
        @(negedge clk);
        check("empty_idle", 32'(busy), 32'd0);
        check("empty_starts", n_start - bs, 32'd0);

        // Song with a rest note
        bs = n_start;
        do_start(2'd2);
        wait_done("rest_done", 200);
        idle(2);
        check("rest_starts", n_start - bs, 32'd2);
        check("rest_note1", 32'(log_rec[bs[7:0]]),
            32'(9'b010_101_001));
        check("rest_note2", 32'(log_rec[bs[7:0] + 1]),
            32'(9'b011_000_001));

`ifdef SONG_SEQ_LOOP_EN
        begin
            int seen;
            logic [8:0] first;
            seen = 0;
            first = '0;
            loop = 1'b1;
            do_start(2'd2);
            for (int k = 0; k < 300 && seen < 3; k++) begin
                @(negedge clk);
                if (bus.snd_start) begin
                    seen++;
                    if (seen == 1) begin
                        first = {bus.snd_octave, bus.snd_note,
                            bus.snd_length};
                    end else if (seen == 3) begin
                        check("loop_note3", {bus.snd_octave,
                            bus.snd_note, bus.snd_length}, 32'(first));
                        check("loop_pos", 32'(position), 32'd0);
                    end
                end
            end
            check("loop_seen", seen, 32'd3);
            check("loop_nodone", 32'(done), 32'd0);
            stop = 1'b1;
            @(negedge clk);
            stop = 1'b0;
            loop = 1'b0;
        end
`endif

        // Full 64-record song without end marker
        bs = n_start; bd = n_done;
        do_start(2'd3);
        wait_done("wrap_done", 3000);
        idle(2);
        check("wrap_starts", n_start - bs, 32'd64);
        check("wrap_dones", n_done - bd, 32'd1);
        check("wrap_last", 32'(log_rec[bs[7:0] + 63]),
            32'(9'b111_001_000));

        // Asynchronous reset mid-GAP
        do_start(2'd1);
        idle(4);
        for (int k = 0; k < 50; k++) begin
            if (bus.snd_over) break;
            @(negedge clk);
        end
        check("gap_over", 32'(bus.snd_over), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        idle(2);
        rst_n = 1'b1;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors",
            n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Autoplay controller for the single shared note-playback engine (Sound: octave/note/length in, start, over out).
- Fetches note records for the selected song from a synchronous song ROM and issues one note at a time to the engine.
- Waits for each note to finish, then inserts a fixed silent gap before the next note.
- Supports start, stop and pause at note boundaries; sits beside free mode, with the mode mux choosing which block drives the engine.

Parameters:
- ADDR_W, 8, total ROM address width: {song id, offset}.
- SONG_W, 2, song select width; offset width OFS_W = ADDR_W-SONG_W.
- GAP_CYCLES, 5000000, silent clocks between notes (minimum 1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begin playing song_sel.
- stop  in  1  one-cycle pulse; abort and return to idle.
- pause_tgl  in  1  one-cycle pulse; toggle the pause request.
- song_sel  in  SONG_W  song to play; sampled on accepted start only.
- rom_addr  out  ADDR_W  song ROM address.
- rom_data  in  10  record: [9] end marker, [8:6] octave, [5:3] note (0 = rest), [2:0] length; valid one cycle after rom_addr.
- snd_start  out  1  one-cycle start pulse to the engine.
- snd_octave  out  3  registered note fields to the engine.
- snd_note  out  3  registered note fields to the engine.
- snd_length  out  3  registered note fields to the engine.
- snd_over  in  1  engine idle/finished flag.
- busy  out  1  high in every state except IDLE.
- paused  out  1  high in PAUSED.
- done  out  1  one-cycle pulse on natural song end.
- position  out  OFS_W  offset of the current record.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0: rom_addr, snd_*, position, busy, paused, done.
  - pause_req and song latch are cleared.
- States and transitions:
  - IDLE: on start, latch song_sel, set offset=0, go to FETCH.
  - FETCH (1 cycle): rom_addr={song,offset}; go to LATCH.
  - LATCH (1 cycle): if rom_data[9], go to END. Otherwise register octave/note/length into snd_* and go to PLAY.
  - PLAY (1 cycle): snd_start=1; go to ARM.
  - ARM (1 cycle): snd_over ignored (engine deasserts over the cycle after start); go to WAIT.
  - WAIT: when snd_over=1, load the gap counter with GAP_CYCLES-1 and go to GAP.
  - GAP: decrement each cycle; at 0, offset+1.
    - If pause_req is set, go to PAUSED.
    - Else go to FETCH.
  - PAUSED: on pause_tgl, clear pause_req and go to FETCH.
  - END (1 cycle): done=1; go to IDLE.
- Latency: start accepted at edge t → rom_addr valid during t+1 → snd_start high during t+3.
- Rests (note=0) are issued normally; the engine produces silence for the given length.
- Pause:
  - pause_tgl in any busy state except PAUSED toggles pause_req.
  - Pause takes effect only at the end of GAP; the current note always completes.
  - pause_tgl in IDLE is ignored.
- Stop:
  - From any state, the next state is IDLE.
  - snd_start is forced 0 that cycle; pause_req is cleared; done is not pulsed.
  - snd_* hold their last values.
- start while busy: ignored.
- stop and start in the same cycle: stop wins.
- pause_tgl together with stop: stop wins.
- Offset wrap: if offset reaches 2^OFS_W-1 and that record is not an end marker, treat the end of that note as END; no wrap into the next song.
- position = offset of the record being fetched/played; holds in PAUSED; 0 in IDLE.

Optional Feature:
- Macro SONG_SEQ_LOOP_EN.
- With the macro: extra input port `loop` (1 bit). In LATCH, an end marker with loop=1 sets offset=0 and goes to FETCH with no done pulse. An end marker at offset 0 always goes to END, so an empty song cannot spin.
- Without the macro: no loop port; an end marker always goes to END.

Decomposition:
- Shared constants header:
  - OCTAVE_BITS=3, NOTE_BITS=3, LENGTH_BITS=3.
  - Record field bit positions (END_BIT, OCT_HI/LO, NOTE_HI/LO, LEN_HI/LO).
  - Sequencer state encodings.
- One sub-module, gap_timer: loadable down-counter with a zero flag, width $clog2(GAP_CYCLES).
- The button edge-to-pulse conversion stays upstream in the existing Pulse module.

Test Plan (GAP_CYCLES=4; engine model drops over at start+1 and raises it after length+2 cycles):
- Song 1 = {o4 n1 l2},{o4 n3 l1},{END}. Pulse start at t0 → rom_addr=0x40 at t0+1, snd_start at t0+3 with 4/1/2; second snd_start carries 4/3/1; done pulses once; busy falls the next cycle.
- pause_tgl during the first WAIT → first note completes, paused rises after its gap, no second snd_start. pause_tgl again → FETCH; the second note plays; done pulses.
- stop during WAIT → busy=0 next cycle; no further snd_start; done stays 0; a later start replays from position 0.
- start pulse while busy and stop+start in the same cycle → start ignored, and state is IDLE after the stop.
- Song whose first record is END → done at start+3, zero snd_start pulses. With SONG_SEQ_LOOP_EN and loop=1: a 2-note song repeats; the third snd_start equals the first; position returns to 0.
- Assert rst_n=0 asynchronously mid-GAP → all outputs are 0 immediately, without waiting for a clock edge.
